// File: rtl/emon_counter_bank.sv
// Multi-channel event monitor: NCH saturating counters, each fed by one selected
// bit of a shared event vector, configured through a word-addressed register file.
module emon_counter_bank #(
  parameter int DW   = 32,
  parameter int NCH  = 4,
  parameter int EVW  = 16,
  parameter int SELW = 4,
  parameter int CHAW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [EVW-1:0]    emon_vector,
  input  logic              reg_write,
  input  logic              reg_read,
  input  logic [CHAW+1:0]   reg_addr,
  input  logic [DW-1:0]     reg_data,
  output logic [DW-1:0]     reg_rdata,
  output logic [NCH-1:0]    emon_zero_flag,
  output logic              emon_irq
);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_CYC  = 2'b11;

  localparam logic [1:0] W_COUNT  = 2'd0;
  localparam logic [1:0] W_RELOAD = 2'd1;
  localparam logic [1:0] W_CONFIG = 2'd2;
  localparam logic [1:0] W_STATUS = 2'd3;

  localparam logic [DW-1:0] ONES    = '1;
  localparam logic [DW-1:0] ONES_M1 = {{(DW-1){1'b1}}, 1'b0};
  localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0]   count_q  [NCH];
  logic [DW-1:0]   count_d  [NCH];
  logic [DW-1:0]   reload_q [NCH];
  logic [DW-1:0]   reload_d [NCH];
  logic [SELW-1:0] sel_q    [NCH];
  logic [SELW-1:0] sel_d    [NCH];
  logic [1:0]      mode_q   [NCH];
  logic [1:0]      mode_d   [NCH];
  logic [DW-1:0]   step_val [NCH];
  logic [NCH-1:0]  rld_en_q, rld_en_d;
  logic [NCH-1:0]  irq_en_q, irq_en_d;
  logic [NCH-1:0]  sticky_q, sticky_d;
  logic [NCH-1:0]  ev_q, ev_d;
  logic [NCH-1:0]  term;
  logic [NCH-1:0]  hit;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            irq_q, irq_d;

  logic [(2**SELW)-1:0] ev_pad;
  logic [1:0]           word;
  logic [CHAW-1:0]      ch_idx;
  logic                 ch_valid;
  logic [DW-1:0]        cfg_word;

  assign word     = reg_addr[1:0];
  assign ch_idx   = reg_addr[CHAW+1:2];
  assign ch_valid = int'(ch_idx) < NCH;

  always_comb begin
    ev_pad = '0;
    ev_pad[EVW-1:0] = emon_vector;
    for (int ch = 0; ch < NCH; ch++) begin
      ev_d[ch]     = ev_pad[sel_q[ch]];
      hit[ch]      = reg_write && ch_valid && (int'(ch_idx) == ch);
      term[ch]     = 1'b0;
      step_val[ch] = count_q[ch];
      // Counters saturate at the rails; only the step onto the rail is terminal.
      unique case (mode_q[ch])
        MODE_DOWN: if (ev_q[ch]) begin
          if (count_q[ch] == ONE) begin
            term[ch]     = 1'b1;
            step_val[ch] = rld_en_q[ch] ? reload_q[ch] : '0;
          end else if (count_q[ch] != '0) begin
            step_val[ch] = count_q[ch] - {{(DW-1){1'b0}}, ev_q[ch]};
          end
        end
        MODE_UP, MODE_CYC: if (ev_q[ch] || mode_q[ch] == MODE_CYC) begin
          if (count_q[ch] == ONES_M1) begin
            term[ch]     = 1'b1;
            step_val[ch] = rld_en_q[ch] ? reload_q[ch] : ONES;
          end else if (count_q[ch] != ONES) begin
            step_val[ch] = count_q[ch] + ONE;
          end
        end
        default: ;
      endcase

      count_d[ch]  = step_val[ch];
      reload_d[ch] = reload_q[ch];
      sel_d[ch]    = sel_q[ch];
      mode_d[ch]   = mode_q[ch];
      rld_en_d[ch] = rld_en_q[ch];
      irq_en_d[ch] = irq_en_q[ch];
      sticky_d[ch] = sticky_q[ch];
      if (hit[ch]) begin
        unique case (word)
          W_COUNT: begin
            count_d[ch] = reg_data;
            term[ch]    = 1'b0;
          end
          W_RELOAD: reload_d[ch] = reg_data;
          W_CONFIG: begin
            sel_d[ch]    = reg_data[SELW-1:0];
            mode_d[ch]   = reg_data[SELW+1:SELW];
            rld_en_d[ch] = reg_data[SELW+2];
            irq_en_d[ch] = reg_data[SELW+3];
          end
          W_STATUS: if (reg_data[0]) sticky_d[ch] = 1'b0;
          default: ;
        endcase
      end
      if (term[ch]) sticky_d[ch] = 1'b1;
    end
  end

  always_comb begin
    cfg_word = '0;
    rdata_d  = rdata_q;
    if (ch_valid) begin
      cfg_word[SELW-1:0]    = sel_q[ch_idx];
      cfg_word[SELW+1:SELW] = mode_q[ch_idx];
      cfg_word[SELW+2]      = rld_en_q[ch_idx];
      cfg_word[SELW+3]      = irq_en_q[ch_idx];
    end
    if (reg_read) begin
      rdata_d = '0;
      if (ch_valid) begin
        unique case (word)
          W_COUNT:  rdata_d = count_q[ch_idx];
          W_RELOAD: rdata_d = reload_q[ch_idx];
          W_CONFIG: rdata_d = cfg_word;
          W_STATUS: rdata_d = {{(DW-1){1'b0}}, sticky_q[ch_idx]};
          default:  rdata_d = '0;
        endcase
      end
    end
    irq_d = |(sticky_q & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        count_q[ch]  <= ONES;
        reload_q[ch] <= '0;
        sel_q[ch]    <= '0;
        mode_q[ch]   <= MODE_OFF;
      end
      rld_en_q <= '0;
      irq_en_q <= '0;
      sticky_q <= '0;
      ev_q     <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        count_q[ch]  <= count_d[ch];
        reload_q[ch] <= reload_d[ch];
        sel_q[ch]    <= sel_d[ch];
        mode_q[ch]   <= mode_d[ch];
      end
      rld_en_q <= rld_en_d;
      irq_en_q <= irq_en_d;
      sticky_q <= sticky_d;
      ev_q     <= ev_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) emon_zero_flag[ch] = (count_q[ch] == '0);
  end

  assign reg_rdata = rdata_q;
  assign emon_irq  = irq_q;

endmodule
